// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and helpers for the EX-stage forwarding / hazard unit.
package fwd_hazard_unit_pkg;

    // Select value meaning "take operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // Architectural zero register: never forwarded, never busy.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default mul/div result latency in cycles.
    localparam int MD_LAT_DEFAULT = 4;

    // Width of one select field: must encode 0 (regfile) .. stages.
    function automatic int sel_width(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_md_scoreboard.sv
// Busy-register scoreboard for a single in-flight multi-cycle mul/div op.
module md_scoreboard
    import fwd_hazard_unit_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_accept,
    input  logic [4:0]  md_rd,
    output logic [31:0] busy,
    output logic        md_blocking,
    output logic        md_done,
    output logic [4:0]  md_rd_o
);

    localparam int CW = (MD_LAT < 2) ? 1 : $clog2(MD_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   busy_q, busy_d;
    logic [4:0]    rd_q, rd_d;
    logic          done_q, done_d;
    logic [4:0]    rd_o_q, rd_o_d;

    // A new op may start only when none is in flight or the current one
    // finishes at the end of this cycle.
    assign md_blocking = (cnt_q > CW'(1));
    assign busy        = busy_q;
    assign md_done     = done_q;
    assign md_rd_o     = rd_o_q;

    // Next state: completion first, then a new start so that a same-rd
    // restart leaves the busy bit set for the new owner.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        rd_d   = rd_q;
        done_d = 1'b0;
        rd_o_d = rd_o_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                done_d         = 1'b1;
                rd_o_d         = rd_q;
                busy_d[rd_q]   = 1'b0;
            end
        end
        if (md_accept) begin
            cnt_d = CW'(MD_LAT);
            rd_d  = md_rd;
            if (md_rd != REG_ZERO) begin
                busy_d[md_rd] = 1'b1;
            end
        end
    end

    // State registers; reset discards any in-flight op without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= '0;
            rd_q   <= '0;
            done_q <= 1'b0;
            rd_o_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            rd_q   <= rd_d;
            done_q <= done_d;
            rd_o_q <= rd_o_d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage bypass select over FWD_STAGES producers plus late-result,
// mul/div busy and structural stall generation with a stall-cycle counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int MD_LAT     = MD_LAT_DEFAULT,
    parameter int SELW       = sel_width(FWD_STAGES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC*5-1:0]    ex_src,
    input  logic [NUM_SRC-1:0]      ex_src_vld,
    input  logic [FWD_STAGES*5-1:0] stg_rw,
    input  logic [FWD_STAGES-1:0]   stg_regwr,
    input  logic [FWD_STAGES-1:0]   stg_late,
    input  logic                    ex_advance,
    input  logic                    md_start,
    input  logic [4:0]              md_rd,
    output logic [NUM_SRC*SELW-1:0] fwd_sel,
    output logic                    stall,
    output logic                    md_done,
    output logic [4:0]              md_rd_o,
    output logic [31:0]             stall_cnt
);

    logic [31:0]        busy;
    logic               md_blocking;
    logic               md_accept;
    logic               struct_hz;
    logic [NUM_SRC-1:0] late_src;
    logic [NUM_SRC-1:0] busy_src;
    logic [31:0]        stall_cnt_q, stall_cnt_d;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [4:0]            src;
            logic [FWD_STAGES-1:0] match_vec;
            logic [SELW-1:0]       sel_raw;
            logic                  late_hit;

            assign src = ex_src[gi*5 +: 5];

            for (gj = 0; gj < FWD_STAGES; gj++) begin : g_stg
                assign match_vec[gj] = ex_src_vld[gi] && (src != REG_ZERO) &&
                                       stg_regwr[gj] && (stg_rw[gj*5 +: 5] == src);
            end

            // Priority pick: scan oldest to youngest so the youngest match wins.
            always_comb begin
                sel_raw  = SELW'(FWD_SEL_RF);
                late_hit = 1'b0;
                for (int k = FWD_STAGES; k >= 1; k--) begin
                    if (match_vec[k-1]) begin
                        sel_raw  = SELW'(k);
                        late_hit = (k < FWD_STAGES) && stg_late[k-1];
                    end
                end
            end

            // Late data is not usable yet: read the regfile and stall instead.
            assign fwd_sel[gi*SELW +: SELW] = late_hit ? SELW'(FWD_SEL_RF) : sel_raw;
            assign late_src[gi] = late_hit;
            assign busy_src[gi] = ex_src_vld[gi] && busy[src];
        end
    endgenerate

    assign struct_hz = md_start && md_blocking;
    assign stall     = (|late_src) || (|busy_src) || struct_hz;
    assign md_accept = md_start && !stall && ex_advance;
    assign stall_cnt = stall_cnt_q;

    md_scoreboard #(
        .MD_LAT (MD_LAT)
    ) u_md_sb (
        .clk         (clk),
        .rst         (rst),
        .md_accept   (md_accept),
        .md_rd       (md_rd),
        .busy        (busy),
        .md_blocking (md_blocking),
        .md_done     (md_done),
        .md_rd_o     (md_rd_o)
    );

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (NUM_SRC=2, FWD_STAGES=2, MD_LAT=4).
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ex_src;
    logic [1:0]  ex_src_vld;
    logic [9:0]  stg_rw;
    logic [1:0]  stg_regwr;
    logic [1:0]  stg_late;
    logic        ex_advance;
    logic        md_start;
    logic [4:0]  md_rd;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        md_done;
    logic [4:0]  md_rd_o;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int tnum   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NUM_SRC    (2),
        .FWD_STAGES (2),
        .MD_LAT     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_src     (ex_src),
        .ex_src_vld (ex_src_vld),
        .stg_rw     (stg_rw),
        .stg_regwr  (stg_regwr),
        .stg_late   (stg_late),
        .ex_advance (ex_advance),
        .md_start   (md_start),
        .md_rd      (md_rd),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .md_done    (md_done),
        .md_rd_o    (md_rd_o),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [4:0] s0, s1;
        logic [1:0] vld;
        logic [4:0] r1, r2;
        logic [1:0] wr, lt;
        logic       mds;
        logic [4:0] mdrd;
        logic [1:0] e_sel0, e_sel1;
        logic       e_stall;
        logic       e_done;
        logic [4:0] e_rd;
    } vec_t;

    vec_t exp_q[$];

    function automatic vec_t V(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] vld,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] wr,
                               input logic [1:0] lt, input logic mds, input logic [4:0] mdrd,
                               input logic [1:0] es0, input logic [1:0] es1, input logic est,
                               input logic edn, input logic [4:0] erd);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.vld = vld; v.r1 = r1; v.r2 = r2; v.wr = wr; v.lt = lt;
        v.mds = mds; v.mdrd = mdrd; v.e_sel0 = es0; v.e_sel1 = es1; v.e_stall = est;
        v.e_done = edn; v.e_rd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL t%0d %s: got %0h expected %0h", tnum, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_src     = {v.s1, v.s0};
        ex_src_vld = v.vld;
        stg_rw     = {v.r2, v.r1};
        stg_regwr  = v.wr;
        stg_late   = v.lt;
        ex_advance = 1'b1;
        md_start   = v.mds;
        md_rd      = v.mdrd;
    endtask

    // One cycle: drive at negedge, queue the expectation, compare before the next posedge.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        check("fwd_sel", 32'(fwd_sel), 32'({e.e_sel1, e.e_sel0}));
        check("stall", 32'(stall), 32'(e.e_stall));
        check("md_done", 32'(md_done), 32'(e.e_done));
        if (e.e_done) check("md_rd_o", 32'(md_rd_o), 32'(e.e_rd));
        check("stall_cnt", stall_cnt, 32'(exp_cnt));
        if (e.e_stall) exp_cnt++;
        $display("t%0d src=%0d/%0d sel=%h stall=%b done=%b rd_o=%0d cnt=%0d",
                 tnum, e.s0, e.s1, fwd_sel, stall, md_done, md_rd_o, stall_cnt);
        tnum++;
    endtask

    vec_t tbl[11];
    vec_t idle;
    vec_t cons;

    initial begin
        idle = V(0,0,2'b00, 0,0,2'b00,2'b00, 0,0, 0,0,0,0,0);
        // Combinational forwarding / late-hazard table.
        tbl[0]  = V( 0, 0,2'b00,  0, 0,2'b00,2'b00, 0,0, 0,0,0,0,0);
        tbl[1]  = V( 8, 9,2'b11,  8, 8,2'b11,2'b00, 0,0, 1,0,0,0,0);  // youngest wins
        tbl[2]  = V( 3, 4,2'b11,  7, 4,2'b11,2'b00, 0,0, 0,2,0,0,0);
        tbl[3]  = V( 3, 0,2'b01,  3, 3,2'b10,2'b00, 0,0, 2,0,0,0,0);  // stage1 not writing
        tbl[4]  = V( 3, 0,2'b00,  3, 0,2'b01,2'b00, 0,0, 0,0,0,0,0);  // source not read
        tbl[5]  = V( 0, 5,2'b11,  5, 0,2'b01,2'b01, 0,0, 0,0,1,0,0);  // late at stage1
        tbl[6]  = V( 0, 5,2'b11,  9, 5,2'b11,2'b10, 0,0, 0,2,0,0,0);  // late at final stage ok
        tbl[7]  = V( 0, 0,2'b11,  0, 0,2'b11,2'b00, 0,0, 0,0,0,0,0);  // r0 never matches
        tbl[8]  = V( 6, 0,2'b01,  6, 6,2'b11,2'b01, 0,0, 0,0,1,0,0);
        tbl[9]  = V(10,10,2'b11,  1,10,2'b11,2'b00, 0,0, 2,2,0,0,0);
        tbl[10] = V(11, 0,2'b00, 11, 0,2'b01,2'b01, 0,0, 0,0,0,0,0);

        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        check("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_md_done", 32'(md_done), 32'd0);
        check("rst_md_rd_o", 32'(md_rd_o), 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) step(tbl[i]);

        // mul/div to r0: never busy, completes with rd 0.
        step(V(0,0,2'b00, 0,0,2'b00,2'b00, 1,0, 0,0,0,0,0));
        for (int i = 0; i < 4; i++) step(V(0,0,2'b11, 0,0,2'b00,2'b00, 0,0, 0,0,0,0,0));
        step(V(0,0,2'b11, 0,0,2'b00,2'b00, 0,0, 0,0,0,1,0));

        // mul/div r12, dependent consumer stalls MD_LAT cycles.
        step(V(0,0,2'b00, 0,0,2'b00,2'b00, 1,12, 0,0,0,0,0));
        cons = V(12,0,2'b01, 0,0,2'b00,2'b00, 0,0, 0,0,1,0,0);
        for (int i = 0; i < 4; i++) step(cons);
        step(V(12,0,2'b01, 0,0,2'b00,2'b00, 0,0, 0,0,0,1,12));
        step(V(12,0,2'b01, 0,0,2'b00,2'b00, 0,0, 0,0,0,0,0));

        // Overlapping start: structural stall until the first op's last cycle.
        step(V(0,0,2'b00, 0,0,2'b00,2'b00, 1,13, 0,0,0,0,0));
        step(idle);
        step(V(0,0,2'b00, 0,0,2'b00,2'b00, 1,14, 0,0,1,0,0));
        step(V(0,0,2'b00, 0,0,2'b00,2'b00, 1,14, 0,0,1,0,0));
        step(V(0,0,2'b00, 0,0,2'b00,2'b00, 1,14, 0,0,0,0,0));
        step(V(14,13,2'b11, 0,0,2'b00,2'b00, 0,0, 0,0,1,1,13));
        for (int i = 0; i < 3; i++) step(V(14,13,2'b11, 0,0,2'b00,2'b00, 0,0, 0,0,1,0,0));
        step(V(14,13,2'b11, 0,0,2'b00,2'b00, 0,0, 0,0,0,1,14));

        // Reset while the counter holds 2: op discarded, no done pulse.
        step(V(0,0,2'b00, 0,0,2'b00,2'b00, 1,20, 0,0,0,0,0));
        cons = V(20,0,2'b01, 0,0,2'b00,2'b00, 0,0, 0,0,1,0,0);
        for (int i = 0; i < 3; i++) step(cons);
        #2;
        rst = 1'b1;
        #1;
        check("arst_stall_cnt", stall_cnt, 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_md_done", 32'(md_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) step(V(20,0,2'b01, 0,0,2'b00,2'b00, 0,0, 0,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
